// File: rtl/can_rec_arbiter.sv
// Round-robin arbiter sharing the MOPSHUB CAN-to-elink uplink among up to 16 CAN receive channels.
// Optional grant/drop statistics counters are built when CAN_REC_ARB_STATS_EN is defined.
module can_rec_arbiter #(
    parameter int N_BUSES     = 16,
    parameter int DATA_W      = 76,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         n_buses,
    input  logic [N_BUSES-1:0] bus_en,
    input  logic [N_BUSES-1:0] rec_req,
    input  logic [DATA_W-1:0]  rec_data_mux,
    output logic [N_BUSES-1:0] rec_ack,
    output logic [4:0]         can_rec_select,
    output logic [DATA_W-1:0]  data_rec_uplink,
    output logic               uplink_valid,
    input  logic               uplink_ready,
    output logic               irq_elink_rec,
    output logic               timeout_err,
`ifdef CAN_REC_ARB_STATS_EN
    output logic [15:0]        grant_cnt,
    output logic [7:0]         drop_cnt,
`endif
    output logic               busy
);

    typedef enum logic [2:0] {IDLE, SELECT, LATCH, SEND, DONE} state_t;

    localparam logic [4:0] LAST_INIT = 5'(N_BUSES - 1);
    // uplink_valid stays up for exactly TIMEOUT_CYC cycles before the frame is dropped
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t             state;
    logic [4:0]         last_grant;
    logic [7:0]         wait_cnt;

    logic [N_BUSES-1:0] eligible;
    logic [N_BUSES-1:0] sel_onehot;
    logic               any_elig;
    logic               hi_found;
    logic [4:0]         hi_idx;
    logic [4:0]         lo_idx;
    logic [4:0]         winner;
    logic               req_sel;

    // Ineligible indices above n_buses drop out, so wrapping at N_BUSES equals wrapping at n_buses.
    always_comb begin
        eligible   = '0;
        sel_onehot = '0;
        any_elig   = 1'b0;
        hi_found   = 1'b0;
        hi_idx     = '0;
        lo_idx     = '0;
        req_sel    = 1'b0;
        for (int i = 0; i < N_BUSES; i++) begin
            eligible[i]   = rec_req[i] & bus_en[i] & (5'(i) <= n_buses);
            sel_onehot[i] = (5'(i) == can_rec_select);
            if (eligible[i] && !any_elig) begin
                any_elig = 1'b1;
                lo_idx   = 5'(i);
            end
            if (eligible[i] && !hi_found && (5'(i) > last_grant)) begin
                hi_found = 1'b1;
                hi_idx   = 5'(i);
            end
            if (sel_onehot[i] && rec_req[i]) begin
                req_sel = 1'b1;
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            last_grant      <= LAST_INIT;
            wait_cnt        <= '0;
            can_rec_select  <= '0;
            data_rec_uplink <= '0;
            rec_ack         <= '0;
            uplink_valid    <= 1'b0;
            irq_elink_rec   <= 1'b0;
            timeout_err     <= 1'b0;
            busy            <= 1'b0;
`ifdef CAN_REC_ARB_STATS_EN
            grant_cnt       <= '0;
            drop_cnt        <= '0;
`endif
        end else begin
            rec_ack       <= '0;
            irq_elink_rec <= 1'b0;
            timeout_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state <= SELECT;
                        busy  <= 1'b1;
                    end
                end
                SELECT: begin
                    if (any_elig) begin
                        can_rec_select <= winner;
                        last_grant     <= winner;
                        state          <= LATCH;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                LATCH: begin
                    // A withdrawn request abandons the grant but last_grant keeps the winner.
                    if (req_sel) begin
                        data_rec_uplink <= rec_data_mux;
                        uplink_valid    <= 1'b1;
                        rec_ack         <= sel_onehot;
                        wait_cnt        <= '0;
                        state           <= SEND;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SEND: begin
                    if (uplink_ready) begin
                        uplink_valid  <= 1'b0;
                        irq_elink_rec <= 1'b1;
                        state         <= DONE;
`ifdef CAN_REC_ARB_STATS_EN
                        grant_cnt     <= grant_cnt + 16'd1;
`endif
                    end else if (wait_cnt >= WAIT_LAST) begin
                        uplink_valid <= 1'b0;
                        timeout_err  <= 1'b1;
                        state        <= DONE;
`ifdef CAN_REC_ARB_STATS_EN
                        if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
`endif
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_rec_arbiter.sv
// Scoreboard bench for can_rec_arbiter: expected grants are queued as requests are driven and
// popped when rec_ack fires.
module tb_can_rec_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  n_buses;
    logic [15:0] bus_en;
    logic [15:0] rec_req;
    logic [75:0] rec_data_mux;
    logic [15:0] rec_ack;
    logic [4:0]  can_rec_select;
    logic [75:0] data_rec_uplink;
    logic        uplink_valid;
    logic        uplink_ready;
    logic        irq_elink_rec;
    logic        timeout_err;
    logic        busy;
`ifdef CAN_REC_ARB_STATS_EN
    logic [15:0] grant_cnt;
    logic [7:0]  drop_cnt;
`endif

    logic        mux_mode;
    logic [75:0] fixed_data;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    typedef struct {
        int          bus;
        logic [75:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [75:0] frame(input int b);
        return {12'(b), 64'h0123_4567_89AB_CDEF ^ {16{4'(b)}}};
    endfunction

    // Receive mux model: each bus presents its own recognisable frame.
    assign rec_data_mux = mux_mode ? frame(int'(can_rec_select)) : fixed_data;

    can_rec_arbiter #(.N_BUSES(16), .DATA_W(76), .TIMEOUT_CYC(255)) dut (
        .clk            (clk),
        .rst            (rst),
        .n_buses        (n_buses),
        .bus_en         (bus_en),
        .rec_req        (rec_req),
        .rec_data_mux   (rec_data_mux),
        .rec_ack        (rec_ack),
        .can_rec_select (can_rec_select),
        .data_rec_uplink(data_rec_uplink),
        .uplink_valid   (uplink_valid),
        .uplink_ready   (uplink_ready),
        .irq_elink_rec  (irq_elink_rec),
        .timeout_err    (timeout_err),
`ifdef CAN_REC_ARB_STATS_EN
        .grant_cnt      (grant_cnt),
        .drop_cnt       (drop_cnt),
`endif
        .busy           (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst          = 1'b0;
        rec_req      = '0;
        uplink_ready = 1'b0;
        n_buses      = 5'd15;
        bus_en       = 16'hFFFF;
        mux_mode     = 1'b1;
        sb.delete();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output bit seen);
        seen = (rec_ack != 0);
        for (int t = 0; t < limit && !seen; t++) begin
            step();
            seen = (rec_ack != 0);
        end
    endtask

    task automatic test_reset();
        bit   seen;
        exp_t e;
        logic [15:0] oh;
        rst = 1'b0; rec_req = '0; uplink_ready = 1'b0; n_buses = 5'd15; bus_en = 16'hFFFF;
        mux_mode = 1'b1; fixed_data = '0;
        #3;
        checks++; if (uplink_valid !== 1'b0 || busy !== 1'b0 || rec_ack !== 16'h0) begin
            errors++; $display("FAIL reset_ctrl: valid=%b busy=%b ack=%h want 0", uplink_valid, busy, rec_ack); end
        checks++; if (can_rec_select !== 5'd0 || data_rec_uplink !== 76'h0) begin
            errors++; $display("FAIL reset_data: sel=%0d data=%h want 0", can_rec_select, data_rec_uplink); end
        checks++; if (irq_elink_rec !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: irq=%b to=%b want 0", irq_elink_rec, timeout_err); end
        step(); step();
        rst = 1'b1;
        rec_req = 16'h0004;
        wait_ack(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL reset_presend: no rec_ack, want one"); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (uplink_valid !== 1'b0 || busy !== 1'b0 || rec_ack !== 16'h0 || data_rec_uplink !== 76'h0) begin
            errors++; $display("FAIL reset_midsend: valid=%b busy=%b ack=%h data=%h want 0",
                               uplink_valid, busy, rec_ack, data_rec_uplink); end
        rec_req = 16'h0001;
        step();
        rst = 1'b1;
        uplink_ready = 1'b1;
        sb.push_back('{0, frame(0)});
        wait_ack(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL reset_regrant: no rec_ack, want bus 0"); end
        else begin
            e = sb.pop_front();
            oh = 16'h1 << e.bus;
            checks++; if (can_rec_select !== 5'(e.bus) || rec_ack !== oh) begin
                errors++; $display("FAIL reset_regrant: sel=%0d ack=%h want %0d %h", can_rec_select, rec_ack, e.bus, oh); end
        end
        rec_req = '0;
        step(); step(); step();
    endtask

    task automatic test_single();
        exp_t e;
        apply_reset();
        mux_mode = 1'b0; fixed_data = 76'h123; uplink_ready = 1'b1;
        rec_req = 16'h0008;
        sb.push_back('{3, 76'h123});
        step(); step();
        checks++; if (can_rec_select !== 5'd3 || uplink_valid !== 1'b0) begin
            errors++; $display("FAIL single_c2: sel=%0d valid=%b want 3 0", can_rec_select, uplink_valid); end
        step();
        e = sb.pop_front();
        checks++; if (uplink_valid !== 1'b1 || rec_ack !== 16'h0008) begin
            errors++; $display("FAIL single_c3: valid=%b ack=%h want 1 0008", uplink_valid, rec_ack); end
        checks++; if (data_rec_uplink !== e.data) begin
            errors++; $display("FAIL single_data: got %h want %h", data_rec_uplink, e.data); end
        rec_req = '0;
        step();
        checks++; if (irq_elink_rec !== 1'b1 || uplink_valid !== 1'b0 || rec_ack !== 16'h0) begin
            errors++; $display("FAIL single_c4: irq=%b valid=%b ack=%h want 1 0 0", irq_elink_rec, uplink_valid, rec_ack); end
        step();
        checks++; if (irq_elink_rec !== 1'b0) begin
            errors++; $display("FAIL single_irq_pulse: irq=%b want 0", irq_elink_rec); end
`ifdef CAN_REC_ARB_STATS_EN
        checks++; if (grant_cnt !== 16'd1 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL single_stats: grant=%0d drop=%0d want 1 0", grant_cnt, drop_cnt); end
`endif
        mux_mode = 1'b1;
    endtask

    task automatic run_grants(input string name, input int n);
        bit   seen;
        exp_t e;
        int   last;
        logic [15:0] oh;
        last = 0;
        for (int k = 0; k < n; k++) begin
            wait_ack(20, seen);
            checks++; if (!seen) begin
                errors++; $display("FAIL %s_timeout: no rec_ack for grant %0d", name, k); break; end
            e = sb.pop_front();
            oh = 16'h1 << e.bus;
            checks++; if (can_rec_select !== 5'(e.bus) || rec_ack !== oh || data_rec_uplink !== e.data) begin
                errors++; $display("FAIL %s_grant%0d: sel=%0d ack=%h data=%h want %0d %h %h",
                                   name, k, can_rec_select, rec_ack, data_rec_uplink, e.bus, oh, e.data); end
            if (k > 0) begin
                checks++; if (cyc - last != 5) begin
                    errors++; $display("FAIL %s_spacing%0d: got %0d cycles want 5", name, k, cyc - last); end
            end
            last = cyc;
            step();
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        uplink_ready = 1'b1;
        rec_req = 16'hFFFF;
        for (int i = 0; i <= 16; i++) sb.push_back('{i % 16, frame(i % 16)});
        run_grants("rr", 17);
        rec_req = '0;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_masking();
        apply_reset();
        uplink_ready = 1'b1;
        bus_en = 16'h00F0; n_buses = 5'd5;
        rec_req = 16'hFFFF;
        for (int i = 0; i < 6; i++) sb.push_back('{4 + (i % 2), frame(4 + (i % 2))});
        run_grants("mask", 6);
        rec_req = '0; bus_en = 16'hFFFF; n_buses = 5'd15;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_timeout();
        bit   seen;
        exp_t e;
        int   t0, irqs, acks, tos, vcyc, unstable;
        apply_reset();
        uplink_ready = 1'b0;
        rec_req = 16'h0004;
        sb.push_back('{2, frame(2)});
        wait_ack(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL to_ack: no rec_ack, want bus 2"); end
        e = sb.pop_front();
        checks++; if (rec_ack !== 16'h0004 || data_rec_uplink !== e.data) begin
            errors++; $display("FAIL to_grant: ack=%h data=%h want 0004 %h", rec_ack, data_rec_uplink, e.data); end
        rec_req = '0;
        t0 = cyc; irqs = 0; acks = 0; tos = 0; vcyc = 0; unstable = 0;
        for (int t = 0; t < 300; t++) begin
            step();
            if (irq_elink_rec) irqs++;
            if (rec_ack != 0) acks++;
            if (uplink_valid) begin
                vcyc++;
                if (data_rec_uplink !== e.data) unstable++;
            end
            if (timeout_err) begin tos++; break; end
        end
        checks++; if (tos != 1 || cyc - t0 != 255) begin
            errors++; $display("FAIL to_pulse: pulses=%0d after %0d cycles want 1 after 255", tos, cyc - t0); end
        checks++; if (irqs != 0 || acks != 0 || unstable != 0 || vcyc != 254) begin
            errors++; $display("FAIL to_hold: irq=%0d ack=%0d unstable=%0d valid=%0d want 0 0 0 254",
                               irqs, acks, unstable, vcyc); end
        checks++; if (uplink_valid !== 1'b0) begin
            errors++; $display("FAIL to_valid_drop: valid=%b want 0", uplink_valid); end
        step();
        checks++; if (timeout_err !== 1'b0 || uplink_valid !== 1'b0) begin
            errors++; $display("FAIL to_after: to=%b valid=%b want 0 0", timeout_err, uplink_valid); end
`ifdef CAN_REC_ARB_STATS_EN
        checks++; if (grant_cnt !== 16'd0 || drop_cnt !== 8'd1) begin
            errors++; $display("FAIL to_stats: grant=%0d drop=%0d want 0 1", grant_cnt, drop_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        bit   seen;
        exp_t e;
        apply_reset();
        uplink_ready = 1'b0;
        rec_req = 16'h0002;
        sb.push_back('{1, frame(1)});
        wait_ack(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL bp_ack: no rec_ack, want bus 1"); end
        e = sb.pop_front();
        rec_req = '0;
        for (int t = 0; t < 10; t++) begin
            step();
            checks++; if (uplink_valid !== 1'b1 || data_rec_uplink !== e.data || irq_elink_rec !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b data=%h irq=%b want 1 %h 0",
                                   t, uplink_valid, data_rec_uplink, irq_elink_rec, e.data); end
        end
        uplink_ready = 1'b1;
        step();
        checks++; if (irq_elink_rec !== 1'b1 || uplink_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL bp_done: irq=%b valid=%b to=%b want 1 0 0", irq_elink_rec, uplink_valid, timeout_err); end
`ifdef CAN_REC_ARB_STATS_EN
        checks++; if (grant_cnt !== 16'd1 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL bp_stats: grant=%0d drop=%0d want 1 0", grant_cnt, drop_cnt); end
`endif
    endtask

    task automatic test_withdraw();
        bit   seen;
        exp_t e;
        int   acks, valids;
        apply_reset();
        uplink_ready = 1'b1;
        rec_req = 16'h0080;
        step(); step();
        checks++; if (can_rec_select !== 5'd7) begin
            errors++; $display("FAIL wd_select: sel=%0d want 7", can_rec_select); end
        rec_req = '0;
        step();
        checks++; if (busy !== 1'b0 || uplink_valid !== 1'b0 || rec_ack !== 16'h0) begin
            errors++; $display("FAIL wd_idle: busy=%b valid=%b ack=%h want 0 0 0", busy, uplink_valid, rec_ack); end
        acks = 0; valids = 0;
        for (int t = 0; t < 8; t++) begin
            step();
            if (rec_ack != 0) acks++;
            if (uplink_valid) valids++;
        end
        checks++; if (acks != 0 || valids != 0) begin
            errors++; $display("FAIL wd_quiet: acks=%0d valids=%0d want 0 0", acks, valids); end
        rec_req = 16'h0081;
        sb.push_back('{0, frame(0)});
        wait_ack(10, seen);
        checks++; if (!seen) begin errors++; $display("FAIL wd_next: no rec_ack, want bus 0"); end
        else begin
            e = sb.pop_front();
            checks++; if (can_rec_select !== 5'(e.bus) || rec_ack !== 16'h0001 || data_rec_uplink !== e.data) begin
                errors++; $display("FAIL wd_next: sel=%0d ack=%h want 0 0001", can_rec_select, rec_ack); end
        end
        rec_req = '0;
        step();
`ifdef CAN_REC_ARB_STATS_EN
        checks++; if (grant_cnt !== 16'd1 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL wd_stats: grant=%0d drop=%0d want 1 0", grant_cnt, drop_cnt); end
`endif
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_masking();
        test_timeout();
        test_backpressure();
        test_withdraw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
